// File: rtl/clk_div_sched.sv
// Round-robin owner of the clock divider tap select. A granted tap is applied
// on a falling edge of the divided clock (or after WAIT_MAX cycles), then held.
module clk_div_sched #(
  parameter int          N_REQ     = 4,
  parameter logic [7:0]  DIV_RESET = 8'd24,
  parameter logic [7:0]  DIV_MAX   = 8'd31,
  parameter logic [31:0] WAIT_MAX  = 32'd65535,
  parameter logic [15:0] HOLD_CYC  = 16'd16
) (
  input  logic               i_clk_in,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*8-1:0] i_req_div,
  input  logic               i_tap_fb,
  output logic [7:0]         o_div,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_rej,
  output logic               o_busy,
  output logic               o_timeout,
  output logic [1:0]         o_state
);

  // Handshake: requester i holds i_req[i] and its i_req_div slice stable until
  // o_gnt[i] or o_rej[i] pulses; i_req is sampled only in IDLE, and a request
  // dropped before service is lost.
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [7:0]        r_div, w_div_nxt;
  logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0]  r_rej, w_rej_nxt;
  logic              r_timeout, w_timeout_nxt;
  logic [PW-1:0]     r_rr_ptr, w_rr_nxt;
  logic [PW-1:0]     r_owner, w_owner_nxt;
  logic              r_tap_q;
  logic [31:0]       r_wait_cnt, w_wait_nxt;
  logic [15:0]       r_hold_cnt, w_hold_nxt;
  logic [7:0]        r_pend, w_pend_nxt;

  logic              w_fall;
  logic              w_found;
  logic [PW-1:0]     w_winner;
  logic [PW-1:0]     w_rr_adv;
  logic [7:0]        w_win_div;

  assign w_fall = r_tap_q & ~i_tap_fb;

  // First set request at or above the pointer, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    w_found   = 1'b0;
    w_winner  = '0;
    w_rr_adv  = r_rr_ptr;
    w_win_div = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!w_found && i_req[idx]) begin
        w_found   = 1'b1;
        w_winner  = PW'(idx);
        w_rr_adv  = PW'((idx + 1) % N_REQ);
        w_win_div = i_req_div[idx*8 +: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div;
    w_gnt_nxt     = '0;
    w_rej_nxt     = '0;
    w_timeout_nxt = 1'b0;
    w_rr_nxt      = r_rr_ptr;
    w_owner_nxt   = r_owner;
    w_wait_nxt    = r_wait_cnt;
    w_hold_nxt    = r_hold_cnt;
    w_pend_nxt    = r_pend;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nxt = w_winner;
          w_rr_nxt    = w_rr_adv;
          if (w_win_div > DIV_MAX) begin
            w_rej_nxt[w_winner] = 1'b1;
          end else if (w_win_div == r_div) begin
            w_gnt_nxt[w_winner] = 1'b1;
            w_hold_nxt          = '0;
            w_state_nxt         = S_HOLD;
          end else begin
            w_pend_nxt  = w_win_div;
            w_wait_nxt  = '0;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // An edge coinciding with expiry counts as an edge, not a timeout.
        if (w_fall || (r_wait_cnt == WAIT_MAX - 32'd1)) begin
          w_div_nxt          = r_pend;
          w_gnt_nxt[r_owner] = 1'b1;
          w_timeout_nxt      = ~w_fall;
          w_hold_nxt         = '0;
          w_state_nxt        = S_HOLD;
        end else begin
          w_wait_nxt = r_wait_cnt + 32'd1;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == HOLD_CYC - 16'd1) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_nxt = r_hold_cnt + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_div      <= DIV_RESET;
      r_gnt      <= '0;
      r_rej      <= '0;
      r_timeout  <= 1'b0;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_tap_q    <= 1'b0;
      r_wait_cnt <= '0;
      r_hold_cnt <= '0;
      r_pend     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rej      <= w_rej_nxt;
      r_timeout  <= w_timeout_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_owner    <= w_owner_nxt;
      r_tap_q    <= i_tap_fb;
      r_wait_cnt <= w_wait_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_pend     <= w_pend_nxt;
    end
  end

  assign o_div     = r_div;
  assign o_gnt     = r_gnt;
  assign o_rej     = r_rej;
  assign o_timeout = r_timeout;
  assign o_busy    = (r_state != S_IDLE);
  assign o_state   = r_state;

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed scenarios plus randomized transactions
// checked against a per-transaction timing model of the scheduler.
module tb_clk_div_sched;

  localparam int WM = 100;
  localparam int HC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_div = '0;
  logic        tap_fb = 1'b0;
  logic [7:0]  div;
  logic [3:0]  gnt;
  logic [3:0]  rej;
  logic        busy;
  logic        timeout;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;
  int m_rr = 0;
  logic [7:0] m_div = 8'd24;

  always #5 clk = ~clk;

  clk_div_sched #(.WAIT_MAX(32'd100)) dut (
    .i_clk_in (clk),
    .i_rst    (rst),
    .i_req    (req),
    .i_req_div(req_div),
    .i_tap_fb (tap_fb),
    .o_div    (div),
    .o_gnt    (gnt),
    .o_rej    (rej),
    .o_busy   (busy),
    .o_timeout(timeout),
    .o_state  (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] m, input int rr);
    for (int k = 0; k < 4; k++) begin
      if (m[(rr + k) % 4]) return (rr + k) % 4;
    end
    return -1;
  endfunction

  task automatic test_reset();
    logic [17:0] exp_v;
    exp_v = {4'b0, 4'b0, 1'b0, 1'b0, 8'd24};
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, rej, timeout, busy, div} !== exp_v) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", {gnt, rej, timeout, busy, div}, exp_v);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if ({gnt, rej, timeout, busy, div} !== exp_v) begin
        failures++;
        $display("FAIL reset_idle k=%0d got=%h exp=%h", k, {gnt, rej, timeout, busy, div}, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back_same();
    logic [3:0] e_gnt;
    logic [17:0] exp_v;
    req_div = {8'd24, 8'd24, 8'd24, 8'd24};
    req = 4'b1111;
    for (int k = 1; k <= 68; k++) begin
      tick();
      e_gnt = ((k % 17) == 1 && k <= 52) ? 4'(1 << (k / 17)) : 4'b0;
      exp_v = {e_gnt, 4'b0, 1'b0, ((k % 17) != 0), 8'd24};
      checks++;
      if ({gnt, rej, timeout, busy, div} !== exp_v) begin
        failures++;
        $display("FAIL back_to_back k=%0d got=%h exp=%h", k, {gnt, rej, timeout, busy, div}, exp_v);
      end
      req = req & ~e_gnt;
    end
    m_rr = 0;
  endtask

  task automatic test_wait_edge();
    logic [3:0] e_gnt;
    logic [17:0] exp_v;
    req_div = {8'd0, 8'd0, 8'd5, 8'd0};
    req = 4'b0010;
    tap_fb = 1'b0;
    for (int k = 1; k <= 58; k++) begin
      tick();
      e_gnt = (k == 42) ? 4'b0010 : 4'b0;
      exp_v = {e_gnt, 4'b0, 1'b0, (k < 58), (k >= 42) ? 8'd5 : 8'd24};
      checks++;
      if ({gnt, rej, timeout, busy, div} !== exp_v) begin
        failures++;
        $display("FAIL wait_edge k=%0d got=%h exp=%h", k, {gnt, rej, timeout, busy, div}, exp_v);
      end
      req = 4'b0;
      tap_fb = (k <= 40);
    end
    tap_fb = 1'b0;
    m_rr = 2;
    m_div = 8'd5;
  endtask

  task automatic test_reject();
    logic [3:0] e_gnt, e_rej;
    logic e_busy;
    logic [17:0] exp_v;
    req_div = {8'd5, 8'd40, 8'd0, 8'd5};
    req = 4'b1101;
    for (int k = 1; k <= 35; k++) begin
      tick();
      e_rej = (k == 1) ? 4'b0100 : 4'b0;
      e_gnt = (k == 2) ? 4'b1000 : (k == 19) ? 4'b0001 : 4'b0;
      e_busy = (k >= 2 && k <= 17) || (k >= 19 && k <= 34);
      exp_v = {e_gnt, e_rej, 1'b0, e_busy, 8'd5};
      checks++;
      if ({gnt, rej, timeout, busy, div} !== exp_v) begin
        failures++;
        $display("FAIL reject k=%0d got=%h exp=%h", k, {gnt, rej, timeout, busy, div}, exp_v);
      end
      req = req & ~(e_gnt | e_rej);
    end
    m_rr = 1;
  endtask

  task automatic test_timeout();
    logic [17:0] exp_v;
    req_div = {8'd0, 8'd0, 8'd0, 8'd7};
    req = 4'b0001;
    tap_fb = 1'b0;
    for (int k = 1; k <= 117; k++) begin
      tick();
      exp_v = {(k == 101) ? 4'b0001 : 4'b0, 4'b0, (k == 101), (k < 117),
               (k >= 101) ? 8'd7 : 8'd5};
      checks++;
      if ({gnt, rej, timeout, busy, div} !== exp_v) begin
        failures++;
        $display("FAIL timeout k=%0d got=%h exp=%h", k, {gnt, rej, timeout, busy, div}, exp_v);
      end
      req = 4'b0;
    end
    m_rr = 1;
    m_div = 8'd7;
  endtask

  task automatic test_reset_mid_wait();
    logic [17:0] exp_v;
    req_div = {8'd0, 8'd0, 8'd9, 8'd0};
    req = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_v = {4'b0, 4'b0, 1'b0, 1'b1, 8'd7};
      checks++;
      if ({gnt, rej, timeout, busy, div} !== exp_v) begin
        failures++;
        $display("FAIL mid_wait k=%0d got=%h exp=%h", k, {gnt, rej, timeout, busy, div}, exp_v);
      end
      req = 4'b0;
    end
    #2 rst = 1'b1;
    #1;
    exp_v = {4'b0, 4'b0, 1'b0, 1'b0, 8'd24};
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({gnt, rej, timeout, busy, div} !== exp_v) begin
        failures++;
        $display("FAIL mid_wait_rst k=%0d got=%h exp=%h", k, {gnt, rej, timeout, busy, div}, exp_v);
      end
      tick();
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({gnt, rej, timeout, busy, div} !== exp_v) begin
      failures++;
      $display("FAIL mid_wait_release got=%h exp=%h", {gnt, rej, timeout, busy, div}, exp_v);
    end
    req_div = {8'd24, 8'd0, 8'd0, 8'd24};
    req = 4'b1001;
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_v = {(k == 1) ? 4'b0001 : 4'b0, 4'b0, 1'b0, (k < 17), 8'd24};
      checks++;
      if ({gnt, rej, timeout, busy, div} !== exp_v) begin
        failures++;
        $display("FAIL mid_wait_after k=%0d got=%h exp=%h", k, {gnt, rej, timeout, busy, div}, exp_v);
      end
      req = 4'b0;
    end
    m_rr = 1;
    m_div = 8'd24;
  endtask

  task automatic test_random();
    logic [3:0] mask, e_gnt, e_rej;
    logic [7:0] d [4];
    logic [7:0] old_div, new_div;
    logic rejc, to;
    logic [17:0] exp_v;
    int w, j, g, last, bend, r;
    for (int it = 0; it < 40; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 4);
        case (r)
          0: d[i] = 8'($urandom_range(33, 255));
          1: d[i] = m_div;
          2: d[i] = 8'd31;
          3: d[i] = 8'd32;
          default: d[i] = 8'($urandom_range(0, 31));
        endcase
      end
      r = $urandom_range(0, 3);
      case (r)
        0: j = $urandom_range(1, 30);
        1: j = $urandom_range(WM - 2, WM + 2);
        2: j = WM;
        default: j = $urandom_range(1, WM + 5);
      endcase
      w = pick(mask, m_rr);
      m_rr = (w + 1) % 4;
      old_div = m_div;
      rejc = (d[w] > 8'd31);
      to = 1'b0;
      new_div = old_div;
      if (rejc) begin
        g = -1; bend = 1; last = 2;
      end else if (d[w] == old_div) begin
        g = 1; bend = 1 + HC; last = bend;
      end else begin
        g = (j <= WM) ? j + 1 : WM + 1;
        to = (j > WM);
        new_div = d[w];
        bend = g + HC; last = bend;
      end
      m_div = new_div;
      req_div = {d[3], d[2], d[1], d[0]};
      req = mask;
      tap_fb = (j == 1);
      for (int k = 1; k <= last; k++) begin
        tick();
        e_gnt = (k == g) ? 4'(1 << w) : 4'b0;
        e_rej = (rejc && k == 1) ? 4'(1 << w) : 4'b0;
        exp_v = {e_gnt, e_rej, (k == g) && to, (k < bend),
                 (g > 0 && k >= g) ? new_div : old_div};
        checks++;
        if ({gnt, rej, timeout, busy, div} !== exp_v) begin
          failures++;
          $display("FAIL random it=%0d k=%0d mask=%b w=%0d j=%0d got=%h exp=%h",
                   it, k, mask, w, j, {gnt, rej, timeout, busy, div}, exp_v);
        end
        req = 4'b0;
        tap_fb = (k == j - 1);
      end
      tap_fb = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back_same();
    test_wait_edge();
    test_reject();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Controller for the power-of-two clock divider. It owns the divider's 8-bit tap select and shares it between N_REQ requesters using round-robin arbitration.
- A new tap is applied only on a falling edge of the currently selected divided clock, fed back as tap_fb. A timeout fallback covers a stuck tap.
- A minimum dwell time is enforced after every change.
- Sits between the control logic (requesters) and the divider's div input. Same clock domain as the divider.

Parameters:
- N_REQ, 4, number of requesters.
- DIV_RESET, 8'd24, tap select driven out of reset.
- DIV_MAX, 8'd31, largest legal tap index. Requests above it are rejected.
- WAIT_MAX, 32'd65535, cycles to wait for a tap_fb falling edge before forcing the switch.
- HOLD_CYC, 16'd16, minimum cycles in HOLD after an apply before re-arbitration. Must be at least 1.

Ports:
- clk_in, input, 1, system clock; the divider's source clock.
- rst, input, 1, asynchronous active-high reset.
- req, input, N_REQ, level request per requester.
- req_div, input, N_REQ*8, requested tap; requester i uses bits [8i+7:8i].
- tap_fb, input, 1, divider output, clk_in-synchronous.
- div, output, 8, tap select to the divider (registered).
- gnt, output, N_REQ, one-cycle pulse: request i applied.
- rej, output, N_REQ, one-cycle pulse: request i rejected (tap out of range).
- busy, output, 1, high whenever state is not IDLE.
- timeout, output, 1, one-cycle pulse coincident with a gnt forced by WAIT_MAX expiry.

Behaviour:
Reset (asynchronous, any state):
- state=IDLE, div=DIV_RESET, gnt=0, rej=0, timeout=0.
- rr_ptr=0 (requester 0 has highest priority first), tap_q=0, wait_cnt=0, hold_cnt=0, pend=0, owner=0.

Edge detection:
- tap_q<=tap_fb every cycle in every state.
- fall = tap_q & ~tap_fb.

Request contract:
- A requester holds req[i] and its req_div stable until its gnt[i] or rej[i] pulse.
- req is sampled only in IDLE.
- Deassertion before service is allowed; the request is simply lost.

IDLE:
- If any req bit is set, the winner is the first set bit searching upward from rr_ptr with wrap.
- Registered next cycle:
  - owner<=winner.
  - rr_ptr<=winner+1, mod N_REQ.
- Then one of three cases:
  - req_div[winner] > DIV_MAX: rej[winner]=1; stay IDLE.
  - req_div[winner] == div: gnt[winner]=1; go to HOLD with no wait.
  - Otherwise: pend<=req_div[winner], wait_cnt<=0; go to WAIT.
- Latency: req seen in cycle t gives rej or immediate gnt at cycle t+1.

WAIT:
- wait_cnt increments each cycle.
- On fall, or when wait_cnt == WAIT_MAX-1:
  - Next cycle: div<=pend, gnt[owner]=1, hold_cnt<=0; go to HOLD.
  - timeout=1 only if fall was not seen in the deciding cycle. A fall and the expiry in the same cycle count as an edge, with no timeout.
- req changes are ignored while in WAIT.

HOLD:
- hold_cnt increments each cycle.
- When hold_cnt == HOLD_CYC-1, go to IDLE.
- Requests pending during HOLD are served from IDLE afterwards.

General rules:
- gnt, rej and timeout are registered, at most one bit set, one cycle wide.
- div changes only on a gnt cycle.
- rr_ptr advances on every grant or reject, so no requester can starve another.
- All comparisons are unsigned 8-bit. wait_cnt is 32-bit and hold_cnt is 16-bit; neither wraps, because both are cleared on state entry.
- Reset in the middle of WAIT or HOLD discards pend and emits no gnt.

Test Plan:
- Reset, then idle 10 cycles -> div=24, busy=0, gnt/rej/timeout=0.
- req[1]=1, req_div1=5; tap_fb toggles high then low 40 cycles later -> no change until the falling edge; div=5 and gnt[1] pulse one cycle after the edge; busy low HOLD_CYC cycles later.
- req=4'b1111, all req_div=24 -> gnts serviced in order 0,1,2,3, each one cycle after IDLE entry, separated by HOLD_CYC=16; div stays 24.
- req[2]=1, req_div2=40 -> rej[2] at t+1, div unchanged, state IDLE, rr_ptr=3; req[3] asserted simultaneously is served next.
- tap_fb held 0, req[0] with req_div0=7, WAIT_MAX=100 -> gnt[0] and timeout together 100 cycles after WAIT entry; div=7.
- rst asserted mid-WAIT (req_div=9 pending) -> div returns to 24 asynchronously, no gnt; after release, req[0] wins first.
